// File: rtl/game_pkg.sv
// Shared definitions for the match controller: phase and winner encodings,
// default timing parameters and small helpers used by the RTL and bench.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COUNTDOWN = 3'd1,
    FIGHT     = 3'd2,
    GAME_OVER = 3'd3
  } phase_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'd0,
    WIN_P1   = 2'd1,
    WIN_P2   = 2'd2,
    WIN_DRAW = 2'd3
  } winner_e;

  localparam int unsigned DEF_COUNTDOWN_FRAMES = 180;
  localparam int unsigned DEF_STUN_FRAMES      = 16;
  localparam int unsigned DEF_ROUND_SECONDS    = 99;
  localparam int unsigned DEF_FRAME_HZ         = 60;
  localparam int unsigned DEF_START_LIVES      = 3;

  // Bits needed to hold the values 0..n, never less than one.
  function automatic int ctr_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic logic [1:0] dec_sat(input logic [1:0] v);
    return (v == 2'd0) ? 2'd0 : v - 2'd1;
  endfunction

  // A player at zero always has fewer lives unless both are at zero, so one
  // comparison covers both the knockout and the timeout verdict.
  function automatic winner_e winner_by_lives(input logic [1:0] l1,
                                              input logic [1:0] l2);
    if (l1 > l2) return WIN_P1;
    if (l2 > l1) return WIN_P2;
    return WIN_DRAW;
  endfunction

endpackage

// File: rtl/stun_timer.sv
// Per-player stun timer: a hit loads (or reloads) the frame counter, and the
// stun stays active until the clock after the counter has run down to zero.
module stun_timer
  import game_pkg::*;
#(
  parameter int unsigned STUN_FRAMES = DEF_STUN_FRAMES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic load,
  input  logic frame_tick,
  output logic active
);

  localparam int CW = ctr_width(STUN_FRAMES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          active_q, active_d;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    cnt_d    = cnt_q;
    active_d = active_q;
    if (clear) begin
      cnt_d    = '0;
      active_d = 1'b0;
    end else if (load) begin
      cnt_d    = CW'(STUN_FRAMES);
      active_d = 1'b1;
    end else if (active_q) begin
      if (cnt_q == '0) active_d = 1'b0;
      else if (frame_tick) cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: state updates use non-blocking assignments so all flops sample together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign active = active_q;

endmodule

// File: rtl/match_controller.sv
// Match sequencing for a two-player fighter: countdown, fight with lives,
// stuns and a round clock, then game over with a registered winner.
module match_controller
  import game_pkg::*;
#(
  parameter int unsigned COUNTDOWN_FRAMES = DEF_COUNTDOWN_FRAMES,
  parameter int unsigned STUN_FRAMES      = DEF_STUN_FRAMES,
  parameter int unsigned ROUND_SECONDS    = DEF_ROUND_SECONDS,
  parameter int unsigned FRAME_HZ         = DEF_FRAME_HZ,
  parameter int unsigned START_LIVES      = DEF_START_LIVES
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       frame_tick,
  input  logic       hit1_flag,
  input  logic       hit2_flag,
  output logic [2:0] phase,
  output logic       input_en,
  output logic       stun1,
  output logic       stun2,
  output logic [1:0] lives1,
  output logic [1:0] lives2,
  output logic [6:0] seconds_left,
  output logic [1:0] winner,
  output logic       det_clear
);

  localparam int CDW = ctr_width(COUNTDOWN_FRAMES);
  localparam int FW  = ctr_width(FRAME_HZ);
  localparam logic [FW-1:0] FRAME_LAST = (FRAME_HZ < 1) ? '0 : FW'(FRAME_HZ - 1);

  phase_e         phase_q, phase_d;
  winner_e        winner_q, winner_d;
  logic [CDW-1:0] cd_q, cd_d;
  logic [FW-1:0]  fcnt_q, fcnt_d;
  logic [6:0]     sec_q, sec_d;
  logic [1:0]     lives1_q, lives1_d, lives2_q, lives2_d;
  logic           det_clear_q, det_clear_d;
  logic           input_en_q, input_en_d;
  logic           hit1_prev_q, hit2_prev_q;
  logic           rise1, rise2, stun1_load, stun2_load, stun_clear;

  // Edge detection makes one hit cost one life however long the flag stays high.
  assign rise1 = hit1_flag & ~hit1_prev_q;
  assign rise2 = hit2_flag & ~hit2_prev_q;

  always_comb begin
    phase_d     = phase_q;
    winner_d    = winner_q;
    cd_d        = cd_q;
    fcnt_d      = fcnt_q;
    sec_d       = sec_q;
    lives1_d    = lives1_q;
    lives2_d    = lives2_q;
    det_clear_d = 1'b0;
    stun1_load  = 1'b0;
    stun2_load  = 1'b0;
    unique case (phase_q)
      IDLE: if (start) begin
        phase_d     = COUNTDOWN;
        lives1_d    = 2'(START_LIVES);
        lives2_d    = 2'(START_LIVES);
        sec_d       = 7'(ROUND_SECONDS);
        winner_d    = WIN_NONE;
        det_clear_d = 1'b1;
        cd_d        = CDW'(COUNTDOWN_FRAMES);
        fcnt_d      = '0;
      end
      COUNTDOWN: begin
        if (cd_q == '0) phase_d = FIGHT;
        else if (frame_tick) begin
          cd_d = cd_q - 1'b1;
          if (cd_q == CDW'(1)) phase_d = FIGHT;
        end
      end
      FIGHT: begin
        stun2_load = rise1;
        stun1_load = rise2;
        if (rise1) lives2_d = dec_sat(lives2_q);
        if (rise2) lives1_d = dec_sat(lives1_q);
        if (frame_tick) begin
          if (fcnt_q == FRAME_LAST) begin
            fcnt_d = '0;
            if (sec_q != 7'd0) sec_d = sec_q - 7'd1;
          end else begin
            fcnt_d = fcnt_q + 1'b1;
          end
        end
        if (lives1_d == 2'd0 || lives2_d == 2'd0 || sec_d == 7'd0) begin
          phase_d  = GAME_OVER;
          winner_d = winner_by_lives(lives1_d, lives2_d);
        end
      end
      GAME_OVER: if (!start) phase_d = IDLE;
      default: phase_d = IDLE;
    endcase
    input_en_d = (phase_d == FIGHT);
  end

  // Stuns only live inside FIGHT; leaving it wipes them even on a final hit.
  assign stun_clear = (phase_d != FIGHT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q     <= IDLE;
      winner_q    <= WIN_NONE;
      cd_q        <= '0;
      fcnt_q      <= '0;
      sec_q       <= 7'(ROUND_SECONDS);
      lives1_q    <= 2'(START_LIVES);
      lives2_q    <= 2'(START_LIVES);
      det_clear_q <= 1'b0;
      input_en_q  <= 1'b0;
      hit1_prev_q <= 1'b0;
      hit2_prev_q <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      winner_q    <= winner_d;
      cd_q        <= cd_d;
      fcnt_q      <= fcnt_d;
      sec_q       <= sec_d;
      lives1_q    <= lives1_d;
      lives2_q    <= lives2_d;
      det_clear_q <= det_clear_d;
      input_en_q  <= input_en_d;
      hit1_prev_q <= hit1_flag;
      hit2_prev_q <= hit2_flag;
    end
  end

  stun_timer #(.STUN_FRAMES(STUN_FRAMES)) u_stun1 (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (stun_clear),
    .load       (stun1_load),
    .frame_tick (frame_tick),
    .active     (stun1)
  );

  stun_timer #(.STUN_FRAMES(STUN_FRAMES)) u_stun2 (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (stun_clear),
    .load       (stun2_load),
    .frame_tick (frame_tick),
    .active     (stun2)
  );

  assign phase        = phase_q;
  assign winner       = winner_q;
  assign input_en     = input_en_q;
  assign lives1       = lives1_q;
  assign lives2       = lives2_q;
  assign seconds_left = sec_q;
  assign det_clear    = det_clear_q;

endmodule

// File: tb/tb_match_controller.sv
// Scoreboard bench for match_controller: dut_a runs default timing, dut_b a
// short countdown and a two-second round for the timeout verdicts.
module tb_match_controller;
  import game_pkg::*;

  logic clk = 1'b0, reset_n = 1'b0, frame_tick = 1'b0;
  logic start_a = 1'b0, hit1_a = 1'b0, hit2_a = 1'b0;
  logic start_b = 1'b0, hit1_b = 1'b0, hit2_b = 1'b0;

  logic [2:0] phase_a, phase_b;
  logic       input_en_a, stun1_a, stun2_a, det_clear_a;
  logic       input_en_b, stun1_b, stun2_b, det_clear_b;
  logic [1:0] lives1_a, lives2_a, winner_a, lives1_b, lives2_b, winner_b;
  logic [6:0] sec_a, sec_b;

  int n_tests = 0;
  int n_fail  = 0;
  int measured = 0;

  typedef enum {F_PH_A, F_INEN_A, F_STUN1_A, F_STUN2_A, F_L1_A, F_L2_A, F_SEC_A,
                F_WIN_A, F_DCLR_A, F_PH_B, F_INEN_B, F_L1_B, F_L2_B, F_SEC_B,
                F_WIN_B, F_MEAS} field_e;
  typedef struct {
    string  tag;
    field_e f;
    int     exp;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  match_controller dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .frame_tick(frame_tick),
    .hit1_flag(hit1_a), .hit2_flag(hit2_a), .phase(phase_a), .input_en(input_en_a),
    .stun1(stun1_a), .stun2(stun2_a), .lives1(lives1_a), .lives2(lives2_a),
    .seconds_left(sec_a), .winner(winner_a), .det_clear(det_clear_a)
  );

  match_controller #(.COUNTDOWN_FRAMES(4), .ROUND_SECONDS(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .frame_tick(frame_tick),
    .hit1_flag(hit1_b), .hit2_flag(hit2_b), .phase(phase_b), .input_en(input_en_b),
    .stun1(stun1_b), .stun2(stun2_b), .lives1(lives1_b), .lives2(lives2_b),
    .seconds_left(sec_b), .winner(winner_b), .det_clear(det_clear_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input field_e f);
    case (f)
      F_PH_A:    return 32'(phase_a);
      F_INEN_A:  return 32'(input_en_a);
      F_STUN1_A: return 32'(stun1_a);
      F_STUN2_A: return 32'(stun2_a);
      F_L1_A:    return 32'(lives1_a);
      F_L2_A:    return 32'(lives2_a);
      F_SEC_A:   return 32'(sec_a);
      F_WIN_A:   return 32'(winner_a);
      F_DCLR_A:  return 32'(det_clear_a);
      F_PH_B:    return 32'(phase_b);
      F_INEN_B:  return 32'(input_en_b);
      F_L1_B:    return 32'(lives1_b);
      F_L2_B:    return 32'(lives2_b);
      F_SEC_B:   return 32'(sec_b);
      F_WIN_B:   return 32'(winner_b);
      default:   return 32'(measured);
    endcase
  endfunction

  task automatic sb_push(input string tag, input field_e f, input int exp);
    exp_t e;
    e.tag = tag;
    e.f   = f;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic sb_drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.f), 32'(e.exp));
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // One frame tick every four clocks; returns on a falling edge.
  task automatic tick(input int n = 1);
    repeat (n) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step(3);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    step(2);
    sb_push("rst_phase", F_PH_A, IDLE);
    sb_push("rst_inen", F_INEN_A, 0);
    sb_push("rst_stun1", F_STUN1_A, 0);
    sb_push("rst_stun2", F_STUN2_A, 0);
    sb_push("rst_lives1", F_L1_A, 3);
    sb_push("rst_lives2", F_L2_A, 3);
    sb_push("rst_sec", F_SEC_A, 99);
    sb_push("rst_win", F_WIN_A, WIN_NONE);
    sb_push("rst_dclr", F_DCLR_A, 0);
    sb_push("rst_sec_b", F_SEC_B, 2);
    sb_drain();
    reset_n = 1'b1;
    step();

    // Match A1: countdown, simultaneous hits, stun retrigger, reset mid-stun.
    start_a = 1'b1;
    step();
    sb_push("cd_enter", F_PH_A, COUNTDOWN);
    sb_push("cd_dclr", F_DCLR_A, 1);
    sb_push("cd_inen", F_INEN_A, 0);
    sb_drain();
    start_a = 1'b0;
    step();
    sb_push("dclr_one_clk", F_DCLR_A, 0);
    sb_drain();
    hit1_a = 1'b1;
    step();
    hit1_a = 1'b0;
    step();
    sb_push("cd_hit_ignored", F_L2_A, 3);
    sb_drain();
    tick(179);
    sb_push("cd_179_phase", F_PH_A, COUNTDOWN);
    sb_push("cd_179_inen", F_INEN_A, 0);
    sb_drain();
    tick();
    sb_push("cd_180_phase", F_PH_A, FIGHT);
    sb_push("cd_180_inen", F_INEN_A, 1);
    sb_drain();

    hit1_a = 1'b1;
    hit2_a = 1'b1;
    step();
    sb_push("sim_lives1", F_L1_A, 2);
    sb_push("sim_lives2", F_L2_A, 2);
    sb_push("sim_stun1", F_STUN1_A, 1);
    sb_push("sim_stun2", F_STUN2_A, 1);
    sb_drain();
    hit1_a = 1'b0;
    hit2_a = 1'b0;
    step();
    tick(4);
    hit2_a = 1'b1;
    step();
    hit2_a = 1'b0;
    sb_push("retrig_lives1", F_L1_A, 1);
    sb_drain();
    step();
    tick(14);
    sb_push("retrig_stun1_held", F_STUN1_A, 1);
    sb_push("retrig_stun2_done", F_STUN2_A, 0);
    sb_drain();

    reset_n = 1'b0;
    #1;
    sb_push("mid_rst_phase", F_PH_A, IDLE);
    sb_push("mid_rst_stun1", F_STUN1_A, 0);
    sb_push("mid_rst_lives1", F_L1_A, 3);
    sb_push("mid_rst_lives2", F_L2_A, 3);
    sb_push("mid_rst_inen", F_INEN_A, 0);
    sb_drain();
    step(2);
    reset_n = 1'b1;
    step();

    // Match A2: single long hit, stun length, round clock, KO, game over.
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    tick(180);
    hit1_a = 1'b1;
    step();
    sb_push("hit_lives2", F_L2_A, 2);
    sb_push("hit_stun2", F_STUN2_A, 1);
    sb_drain();
    step(4);
    hit1_a = 1'b0;
    step();
    sb_push("hit_once", F_L2_A, 2);
    sb_drain();
    measured = 0;
    while (stun2_a && measured < 40) begin
      tick();
      measured++;
    end
    sb_push("stun2_ticks", F_MEAS, 16);
    sb_drain();
    tick(44);
    sb_push("sec_after_60", F_SEC_A, 98);
    sb_drain();
    start_a = 1'b1;
    hit1_a = 1'b1;
    step();
    hit1_a = 1'b0;
    sb_push("ko_lives2_1", F_L2_A, 1);
    sb_push("ko_still_fight", F_PH_A, FIGHT);
    sb_drain();
    step();
    hit1_a = 1'b1;
    step();
    hit1_a = 1'b0;
    sb_push("ko_lives2_0", F_L2_A, 0);
    sb_push("ko_phase", F_PH_A, GAME_OVER);
    sb_push("ko_winner", F_WIN_A, WIN_P1);
    sb_push("ko_inen", F_INEN_A, 0);
    sb_push("ko_stun2_cleared", F_STUN2_A, 0);
    sb_drain();
    step();
    hit2_a = 1'b1;
    step();
    hit2_a = 1'b0;
    sb_push("go_hit_ignored", F_L1_A, 3);
    sb_push("go_held", F_PH_A, GAME_OVER);
    sb_drain();
    start_a = 1'b0;
    step();
    sb_push("go_to_idle", F_PH_A, IDLE);
    sb_push("idle_win_held", F_WIN_A, WIN_P1);
    sb_drain();

    // Match B: two-second round, draw on timeout, then P2 ahead on timeout.
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    tick(4);
    sb_push("b_fight", F_PH_B, FIGHT);
    sb_push("b_sec2", F_SEC_B, 2);
    sb_drain();
    tick(60);
    sb_push("b_sec1", F_SEC_B, 1);
    sb_drain();
    tick(59);
    sb_push("b_119_fight", F_PH_B, FIGHT);
    sb_drain();
    start_b = 1'b1;
    tick();
    sb_push("b_to_phase", F_PH_B, GAME_OVER);
    sb_push("b_to_sec0", F_SEC_B, 0);
    sb_push("b_to_draw", F_WIN_B, WIN_DRAW);
    sb_push("b_to_inen", F_INEN_B, 0);
    sb_drain();
    start_b = 1'b0;
    step();
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    sb_push("b2_restart", F_PH_B, COUNTDOWN);
    sb_push("b2_win_clear", F_WIN_B, WIN_NONE);
    sb_drain();
    tick(4);
    hit2_b = 1'b1;
    step();
    hit2_b = 1'b0;
    sb_push("b2_lives1", F_L1_B, 2);
    sb_drain();
    step();
    tick(119);
    start_b = 1'b1;
    tick();
    sb_push("b2_phase", F_PH_B, GAME_OVER);
    sb_push("b2_winner", F_WIN_B, WIN_P2);
    sb_push("b2_lives2", F_L2_B, 3);
    sb_drain();
    start_b = 1'b0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/match_controller.md
MATCH_CONTROLLER -- requirements
Module: match_controller

Interface
REQ-001 SHALL have parameters: COUNTDOWN_FRAMES, default 180, length of the pre-fight countdown in frame ticks.
REQ-002 SHALL have parameter STUN_FRAMES, default 16, stun duration in frame ticks.
REQ-003 SHALL have parameter ROUND_SECONDS, default 99, fight time limit.
REQ-004 SHALL have parameter FRAME_HZ, default 60, frame ticks per second.
REQ-005 SHALL have parameter START_LIVES, default 3, lives per player.
REQ-006 SHALL have port clk  in  1  system clock; one clock; all state on rising edge.
REQ-007 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-008 SHALL have port start  in  1  level, request to begin match.
REQ-009 SHALL have port frame_tick  in  1  one-clk pulse per video frame.
REQ-010 SHALL have port hit1_flag  in  1  hit detector flag: player 1 landed a hit.
REQ-011 SHALL have port hit2_flag  in  1  hit detector flag: player 2 landed a hit.
REQ-012 SHALL have port phase  out  3  current FSM state encoding.
REQ-013 SHALL have port input_en  out  1  player FSMs may act.
REQ-014 SHALL have ports stun1, stun2  out  1 each  player stunned.
REQ-015 SHALL have ports lives1, lives2  out  2 each  remaining lives.
REQ-016 SHALL have port seconds_left  out  7  round clock.
REQ-017 SHALL have port winner  out  2  0 none, 1 P1, 2 P2, 3 draw.
REQ-018 SHALL have port det_clear  out  1  one-clk pulse that clears the hit detector.

Function
REQ-019 SHALL implement states IDLE, COUNTDOWN, FIGHT, GAME_OVER.
REQ-020 IDLE -> COUNTDOWN on start=1; on entry: lives <= START_LIVES, seconds_left <= ROUND_SECONDS, winner <= 0, det_clear pulses for 1 clk.
REQ-021 COUNTDOWN: decrement frame counter on frame_tick; -> FIGHT in the cycle the counter reaches 0 (after exactly COUNTDOWN_FRAMES ticks); input_en=0 throughout.
REQ-022 FIGHT: input_en=1 unless that player is stunned; input_en is the global enable, and player FSMs additionally gate on their own stunX.
REQ-023 Hits SHALL be detected on the rising edge of hitX_flag (registered previous value), so 1 hit = 1 life regardless of flag width.
REQ-024 Rising hit1_flag: lives2 decrements (saturating at 0); stun2 asserts next clk; stun2 counter loads STUN_FRAMES.
REQ-025 Rising hit2_flag symmetric for lives1/stun1.
REQ-026 Both edges in the same clk: both decrement and both stun.
REQ-027 Hit during active stun: counter reloads to STUN_FRAMES (retrigger), lives still decrement.
REQ-028 Stun counter decrements on frame_tick; stunX deasserts in the clk after the counter hits 0.
REQ-029 Hit edges outside FIGHT SHALL be ignored.
REQ-030 Second counter: counts FRAME_HZ frame_ticks, then decrements seconds_left; seconds_left never wraps below 0.
REQ-031 FIGHT -> GAME_OVER when any life count is 0 after update, or when seconds_left reaches 0.
REQ-032 Winner on lives: the player with lives > 0 wins; both at 0 gives draw (3).
REQ-033 Winner on timeout: the player with more lives wins; equal lives gives draw.
REQ-034 Lives exhaustion and timeout in the same clk: the lives rule decides.
REQ-035 GAME_OVER: input_en=0, stuns cleared, outputs held; -> IDLE only when start=0, then a new start=1.
REQ-036 Counter widths SHALL be sized by $clog2 of their parameter; no arithmetic overflow is permitted.

Reset
REQ-037 reset_n=0 SHALL immediately give: phase=IDLE, input_en=0, stun1=stun2=0, lives=START_LIVES, seconds_left=ROUND_SECONDS, winner=0, det_clear=0, all counters and edge registers 0.
REQ-038 Reset mid-FIGHT SHALL abandon the match with no residual stun or pending hit.

Structure
REQ-039 State encodings, winner codes and default parameter values SHALL live in the shared game package (game_pkg).
REQ-040 The two stun timers SHALL be one sub-module, stun_timer (load, frame_tick, active), instantiated twice.

Verification
REQ-041 Countdown: start pulse, 180 ticks -> phase=FIGHT after tick 180, not before; input_en rises with it.
REQ-042 Single hit: hit1_flag high for 5 clks in FIGHT -> lives2 3->2 once; stun2 high for exactly 16 ticks.
REQ-043 Simultaneous hits: hit1 and hit2 rise in the same clk -> lives 2/2, both stunned.
REQ-044 KO: three P1 hits -> lives2=0, phase=GAME_OVER, winner=1, input_en=0.
REQ-045 Timeout: ROUND_SECONDS=2, no hits -> GAME_OVER after 120 ticks, winner=3; a repeat run with one P2 hit gives winner=2.
REQ-046 Reset mid-stun: assert reset_n=0 during stun1 -> stun1=0, lives=3, phase=IDLE in the same cycle.
